// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data RAM port among NUM_CORES requesters.
// Sequences address setup, a single-cycle RD/WR strobe and a registered completion.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration from rr_ptr
// SETUP  | address/data driven to RAM, range check
// STROBE | RD or WR strobe is registered out for the next cycle
// DONE   | read data captured, ack/err registered out, rr_ptr advanced
module data_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_wr,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic                        core_err,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [2:0]                  grant_id,
    output logic                        busy,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wr,
    output logic                        mem_rd,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [2:0]      LAST_ID   = 3'(NUM_CORES - 1);

    logic [1:0]        state;
    logic [2:0]        rr_ptr;
    logic [2:0]        owner;
    logic              wr_q;
    logic              err_q;
    logic              found;
    logic [2:0]        pick;
    logic              wr_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              out_of_range;
    logic [2:0]        rr_next;

    // Lowest requester overall, then overridden by the lowest at or above rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_req[i]) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_req[i] && (3'(i) >= rr_ptr)) begin
                pick = 3'(i);
            end
        end
    end

    always_comb begin
        wr_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick == 3'(i)) begin
                wr_sel    = core_wr[i];
                addr_sel  = core_addr[i*ADDR_W +: ADDR_W];
                wdata_sel = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign out_of_range = ({1'b0, mem_addr} >= DEPTH_LIM);
    assign rr_next      = (owner == LAST_ID) ? 3'd0 : owner + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            core_ack   <= '0;
            core_err   <= 1'b0;
            core_rdata <= '0;
        end else begin
            mem_wr   <= (state == STROBE) && wr_q;
            mem_rd   <= (state == STROBE) && !wr_q;
            core_ack <= '0;
            core_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= pick;
                        grant_id  <= pick;
                        busy      <= 1'b1;
                        wr_q      <= wr_sel;
                        mem_addr  <= addr_sel;
                        mem_wdata <= wdata_sel;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    err_q <= out_of_range;
                    state <= out_of_range ? DONE : STROBE;
                end
                STROBE: begin
                    state <= DONE;
                end
                DONE: begin
                    // mem_rd is high during this cycle, so RAM output is valid here
                    core_ack   <= NUM_CORES'(1) << owner;
                    core_err   <= err_q;
                    core_rdata <= (err_q || wr_q) ? '0 : mem_rdata;
                    rr_ptr     <= rr_next;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
